// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg : shared widths, FSM states and alignment helper for the    |
// |            data-memory master.                                       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package dmem_pkg;

  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } dmem_state_e;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_master : single-outstanding load/store initiator that sequences |
// |               edge-triggered mem_read/mem_write strobes to datamem.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module dmem_master
  import dmem_pkg::*;
#(
  parameter int AW          = DMEM_AW,
  parameter int DW          = DMEM_DW,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_writeData,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_readdata
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] C_WAIT_LAST = CW'(WAIT_CYCLES);

  dmem_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic [AW-1:0] mem_address_q, mem_address_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_err_d    = resp_err_q;
    resp_rdata_d  = resp_rdata_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    // Strobes are single-cycle pulses: low unless the FSM is entering STROBE.
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          req_ready_d = 1'b0;
          if (is_misaligned(req_addr[1:0])) begin
            // Bus lines keep their previous values; no access is made.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d       = SETUP;
            mem_address_d = req_addr;
            mem_wdata_d   = req_wdata;
            resp_err_d    = 1'b0;
            resp_rdata_d  = '0;
          end
        end
      end
      SETUP: begin
        state_d     = STROBE;
        mem_read_d  = ~write_q;
        mem_write_d = write_q;
      end
      STROBE: begin
        state_d = WAIT;
        cnt_d   = CW'(1);
      end
      WAIT: begin
        if (cnt_q == C_WAIT_LAST) begin
          state_d      = RESP;
          cnt_d        = '0;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? '0 : mem_readdata;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_address   = mem_address_q;
  assign mem_writeData = mem_wdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_master : directed bench for dmem_master with an edge-driven  |
// |                  datamem model; WAIT_CYCLES 1 and 3 instances.        |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_dmem_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: WAIT_CYCLES = 1
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_address, mem_writeData;
  logic [31:0] mem_readdata = '0;

  // Instance B: WAIT_CYCLES = 3, loads only
  logic        req_valid_b = 1'b0, resp_ready_b = 1'b0;
  logic [31:0] req_addr_b = '0;
  logic        req_ready_b, resp_valid_b, resp_err_b, mem_read_b, mem_write_b;
  logic [31:0] resp_rdata_b, mem_address_b, mem_writeData_b;
  logic [31:0] mem_readdata_b = '0;

  dmem_master u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_read(mem_read), .mem_write(mem_write), .mem_readdata(mem_readdata)
  );

  dmem_master #(.WAIT_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(1'b0),
    .req_addr(req_addr_b), .req_wdata(32'h0),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b), .resp_rdata(resp_rdata_b),
    .resp_err(resp_err_b), .mem_address(mem_address_b), .mem_writeData(mem_writeData_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_readdata(mem_readdata_b)
  );

  // Datamem models: act only on strobe rising edges.
  logic [31:0] mem_a [0:63];
  logic [31:0] model [0:63];
  always @(posedge mem_write) mem_a[mem_address[7:2]] <= mem_writeData;
  always @(posedge mem_read)  mem_readdata <= mem_a[mem_address[7:2]];
  always @(posedge mem_read_b) mem_readdata_b <= mem_address_b ^ 32'hA5A5_0000;

  // Strobe monitors
  int rise_rd = 0, rise_wr = 0, both_hi = 0, long_pulse = 0, min_gap = 1000, low_run = 1000;
  int rise_b = 0, both_hi_b = 0, min_gap_b = 1000, low_run_b = 1000;
  logic prev_s = 1'b0, prev_s_b = 1'b0;

  always @(negedge clk) begin
    if (mem_read && mem_write) both_hi <= both_hi + 1;
    if (mem_read || mem_write) begin
      if (!prev_s) begin
        if (low_run < min_gap) min_gap <= low_run;
        if (mem_read) rise_rd <= rise_rd + 1;
        else          rise_wr <= rise_wr + 1;
      end else begin
        long_pulse <= long_pulse + 1;
      end
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
    end
    prev_s <= mem_read || mem_write;
  end

  always @(negedge clk) begin
    if (mem_read_b && mem_write_b) both_hi_b <= both_hi_b + 1;
    if (mem_read_b || mem_write_b) begin
      if (!prev_s_b) begin
        if (low_run_b < min_gap_b) min_gap_b <= low_run_b;
        rise_b <= rise_b + 1;
      end
      low_run_b <= 0;
    end else begin
      low_run_b <= low_run_b + 1;
    end
    prev_s_b <= mem_read_b || mem_write_b;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called #1 after a posedge with instance A idle; leaves it idle again.
  task automatic op_a(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_write = w; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("resp_arrives", {31'b0, resp_valid}, 32'd1);
    rdata = resp_rdata; err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic op_b(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
    req_addr_b = addr; req_valid_b = 1'b1;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    lat = 0;
    while (!resp_valid_b && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata_b;
    resp_ready_b = 1'b1;
    @(posedge clk); #1;
    resp_ready_b = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, hold, wd, addr;
    logic        er, w;
    int          lat, r0, w0, idx, mis;

    for (int i = 0; i < 64; i++) begin
      mem_a[i] <= (i * 32'h0101_0101) ^ 32'h5A5A_0000;
      model[i]  = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",  {31'b0, req_ready},  32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err",   {31'b0, resp_err},   32'd0);
    chk("rst_resp_rdata", resp_rdata,          32'd0);
    chk("rst_strobes",    {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr",   mem_address,   32'd0);
    chk("rst_mem_wdata",  mem_writeData, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Store then load at 0x10
    w0 = rise_wr;
    op_a(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    model[4] = 32'hDEADBEEF;
    chk("st_lat", lat, 3);
    chk("st_rdata", rd, 32'd0);
    chk("st_err", {31'b0, er}, 32'd0);
    chk("st_one_wr_pulse", rise_wr - w0, 1);
    r0 = rise_rd;
    op_a(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("ld_lat", lat, 3);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    chk("ld_err", {31'b0, er}, 32'd0);
    chk("ld_one_rd_pulse", rise_rd - r0, 1);

    // Misaligned load
    r0 = rise_rd; w0 = rise_wr;
    op_a(1'b0, 32'h06, 32'h0, rd, er, lat);
    chk("mis_lat", lat, 0);
    chk("mis_err", {31'b0, er}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_no_strobe", (rise_rd - r0) + (rise_wr - w0), 0);

    // Backpressured response with a second request pending
    req_write = 1'b0; req_addr = 32'h20; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_lat", lat, 3);
    hold = model[8];
    r0 = rise_rd;
    req_addr = 32'h24; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'b0, resp_valid}, 32'd1);
      chk("stall_rdata", resp_rdata, hold);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    chk("stall_ignored", rise_rd - r0, 0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    op_a(1'b0, 32'h24, 32'h0, rd, er, lat);
    chk("pending_rdata", rd, model[9]);
    chk("pending_lat", lat, 3);

    // WAIT_CYCLES = 3 back-to-back loads
    op_b(32'h0, rd, lat);
    chk("w3_lat0", lat, 5);
    chk("w3_rdata0", rd, 32'hA5A5_0000);
    op_b(32'h4, rd, lat);
    chk("w3_lat1", lat, 5);
    chk("w3_rdata1", rd, 32'hA5A5_0004);
    chk("w3_rises", rise_b, 2);
    chk("w3_gap_ge5", {31'b0, (min_gap_b >= 5)}, 32'd1);
    chk("w3_never_both", both_hi_b, 0);

    // Reset during the strobe cycle of a store
    req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rs_strobe_high", {31'b0, mem_write}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rs_strobe_drop", {31'b0, mem_write}, 32'd0);
    chk("rs_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rs_addr_cleared", mem_address, 32'd0);
    model[12] = 32'hCAFEF00D;  // the write edge already reached the memory
    repeat (4) @(posedge clk);
    #1;
    chk("rs_no_resp", {31'b0, resp_valid}, 32'd0);
    op_a(1'b0, 32'h30, 32'h0, rd, er, lat);
    chk("rs_next_load", rd, 32'hCAFEF00D);
    chk("rs_next_lat", lat, 3);

    // Random mixed traffic against the word-array model
    for (int n = 0; n < 1000; n++) begin
      w   = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 63));
      mis = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      addr = (32'(idx) << 2) | 32'(mis);
      wd  = $urandom;
      op_a(w, addr, wd, rd, er, lat);
      chk("rnd_err", {31'b0, er}, {31'b0, (mis != 0)});
      chk("rnd_rdata", rd, (mis != 0 || w) ? 32'd0 : model[idx]);
      if (mis == 0 && w) model[idx] = wd;
    end

    @(negedge clk);
    chk("never_both", both_hi, 0);
    chk("pulse_one_cycle", long_pulse, 0);
    chk("gap_ge3", {31'b0, (min_gap >= 3)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
